// File: rtl/multi_button_debouncer.sv
// multi_button_debouncer
//   N-channel push-button debouncer. Each channel has its own synchroniser,
//   stability counter and four-state FSM (RELEASED, PRESS_PEND, PRESSED,
//   RELEASE_PEND). One shared divider produces the sample tick, and the FSMs
//   advance only on tick cycles. A change is accepted once STABLE_TICKS
//   consecutive tick samples agree with it.
//
//   Optional feature: define DEBOUNCE_REPEAT_EN to build per-channel
//   auto-repeat counters. Without it, BTN_repeat is tied to 0.
//
// Ports
//   clock        in   1      system clock
//   reset        in   1      synchronous, active-high reset
//   BTN          in   N_BTN  raw asynchronous buttons, 1 = pressed
//   BTN_state    out  N_BTN  debounced level (registered)
//   BTN_press    out  N_BTN  one-clock strobe on an accepted 0->1
//   BTN_release  out  N_BTN  one-clock strobe on an accepted 1->0
//   BTN_repeat   out  N_BTN  one-clock auto-repeat strobe
module multi_button_debouncer #(
    parameter int N_BTN         = 5,
    parameter int TICK_DIV      = 100000,
    parameter int STABLE_TICKS  = 10,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] BTN,
    output logic [N_BTN-1:0] BTN_state,
    output logic [N_BTN-1:0] BTN_press,
    output logic [N_BTN-1:0] BTN_release,
    output logic [N_BTN-1:0] BTN_repeat
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_fsm_e;

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int CNT_W  = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    generate
        if (TICK_DIV < 2 || STABLE_TICKS < 1 || SYNC_STAGES < 2 ||
            REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
            $error("multi_button_debouncer: illegal parameter value");
        end
    endgenerate

    // ---------------- input synchroniser ----------------
    logic [N_BTN-1:0] sync_q [SYNC_STAGES];
    logic [N_BTN-1:0] smp;

    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the pre-edge value of its neighbours, like a real shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= BTN;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign smp = sync_q[SYNC_STAGES-1];

    // ---------------- shared sample tick ----------------
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;

    assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset || tick) tick_cnt_q <= '0;
        else               tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end

    // ---------------- per-channel FSM ----------------
    btn_fsm_e         state_q [N_BTN];
    btn_fsm_e         state_d [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_d   [N_BTN];
    logic [N_BTN-1:0] press_evt;
    logic [N_BTN-1:0] release_evt;
    logic [N_BTN-1:0] repeat_evt;

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]     = state_q[i];
            cnt_d[i]       = cnt_q[i];
            press_evt[i]   = 1'b0;
            release_evt[i] = 1'b0;
            if (tick) begin
                case (state_q[i])
                    RELEASED: if (smp[i]) begin
                        if (STABLE_TICKS == 1) begin
                            state_d[i]   = PRESSED;
                            press_evt[i] = 1'b1;
                        end else begin
                            state_d[i] = PRESS_PEND;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                    PRESS_PEND: begin
                        if (!smp[i]) begin
                            state_d[i] = RELEASED;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i]   = PRESSED;
                            cnt_d[i]     = '0;
                            press_evt[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    PRESSED: if (!smp[i]) begin
                        if (STABLE_TICKS == 1) begin
                            state_d[i]     = RELEASED;
                            release_evt[i] = 1'b1;
                        end else begin
                            state_d[i] = RELEASE_PEND;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                    RELEASE_PEND: begin
                        if (smp[i]) begin
                            state_d[i] = PRESSED;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i]     = RELEASED;
                            cnt_d[i]       = '0;
                            release_evt[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    // ---------------- auto-repeat ----------------
    // The counter restarts on every entry to PRESSED and runs while the
    // channel is held. rpt_run_q selects the first-repeat or steady-state
    // interval as the counter's target.
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q [N_BTN];
    logic [RPT_W-1:0] rpt_cnt_d [N_BTN];
    logic [N_BTN-1:0] rpt_run_q;
    logic [N_BTN-1:0] rpt_run_d;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            rpt_cnt_d[i]  = rpt_cnt_q[i];
            rpt_run_d[i]  = rpt_run_q[i];
            repeat_evt[i] = 1'b0;
            if (tick) begin
                if ((state_d[i] == PRESSED && state_q[i] != PRESSED) || state_d[i] == RELEASED) begin
                    rpt_cnt_d[i] = '0;
                    rpt_run_d[i] = 1'b0;
                end else if (state_q[i] == PRESSED || state_q[i] == RELEASE_PEND) begin
                    if (rpt_cnt_q[i] + RPT_W'(1) ==
                        (rpt_run_q[i] ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY))) begin
                        rpt_cnt_d[i]  = '0;
                        rpt_run_d[i]  = 1'b1;
                        repeat_evt[i] = 1'b1;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_BTN; i++) rpt_cnt_q[i] <= '0;
            rpt_run_q <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
            rpt_run_q <= rpt_run_d;
        end
    end
`else
    assign repeat_evt = '0;
`endif

    // ---------------- state and output registers ----------------
    // Events are captured at the deciding tick, then pass through one more
    // output register. The level output is derived from the registered state,
    // so it changes on the same clock as the matching strobe.
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic [N_BTN-1:0] repeat_q;

    // NOTE: the per-channel state/counter arrays are small register banks,
    // not RAM, so they are cleared explicitly on reset along with everything else.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
            press_q     <= '0;
            release_q   <= '0;
            repeat_q    <= '0;
            BTN_state   <= '0;
            BTN_press   <= '0;
            BTN_release <= '0;
            BTN_repeat  <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i]   <= state_d[i];
                cnt_q[i]     <= cnt_d[i];
                BTN_state[i] <= (state_q[i] == PRESSED) || (state_q[i] == RELEASE_PEND);
            end
            press_q     <= press_evt;
            release_q   <= release_evt;
            repeat_q    <= repeat_evt;
            BTN_press   <= press_q;
            BTN_release <= release_q;
            BTN_repeat  <= repeat_q;
        end
    end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Scoreboard bench for multi_button_debouncer.
// Stimulus pushes the expected strobe events (cycle plus press/release/repeat
// masks) into a queue. A monitor pops one entry for every clock on which the
// DUT shows any strobe, and compares that entry with what the DUT shows.
module tb_multi_button_debouncer;

    localparam int N  = 4;
    localparam int TD = 4;   // TICK_DIV
    localparam int ST = 3;   // STABLE_TICKS
    localparam int SS = 2;   // SYNC_STAGES
    localparam int RD = 5;   // REPEAT_DELAY
    localparam int RP = 2;   // REPEAT_PERIOD

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn   = '0;
    logic [N-1:0] btn_state;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;

    multi_button_debouncer #(
        .N_BTN        (N),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .SYNC_STAGES  (SS),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .BTN        (btn),
        .BTN_state  (btn_state),
        .BTN_press  (btn_press),
        .BTN_release(btn_release),
        .BTN_repeat (btn_repeat)
    );

    always #5 clock = ~clock;

    // cyc = number of rising edges so far
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] rpt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   r_cyc    = 0;   // last edge with reset high
    int   last_cyc = 0;   // cycle of the last scheduled strobe

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // First edge at or after x on which the tick is active.
    // Tick edges are r_cyc+TD, r_cyc+2*TD, ...
    function automatic int first_tick(input int x);
        int n = x;
        while (((n - r_cyc) % TD) != 0) n++;
        return n;
    endfunction

    // Expected strobes for a press that is driven after edge d and held for
    // hold clocks past its press strobe. Returns the press strobe cycle and
    // the cycle on which the release is driven.
    task automatic schedule(input logic [N-1:0] mask, input int d, input int hold,
                            output int p, output int dr);
        int rd;
        p  = first_tick(d + SS + 1) + TD * (ST - 1) + 1;
        sb.push_back('{cyc: p, press: mask, rel: '0, rpt: '0});
        dr = p + hold;
        rd = first_tick(dr + SS + 1) + TD * (ST - 1);   // release deciding edge
`ifdef DEBOUNCE_REPEAT_EN
        for (int k = 0; p - 1 + TD * RD + TD * RP * k < rd; k++)
            sb.push_back('{cyc: p + TD * RD + TD * RP * k, press: '0, rel: '0, rpt: mask});
`endif
        sb.push_back('{cyc: rd + 1, press: '0, rel: mask, rpt: '0});
        last_cyc = rd + 1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // ---------------- monitor ----------------
    exp_t got;
    always @(negedge clock) begin
        if (cyc > 0 && (btn_press | btn_release | btn_repeat) != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {btn_press, btn_release, btn_repeat}, 32'd0);
            end else begin
                got = sb.pop_front();
                check("strobe_cycle", cyc, got.cyc);
                check("press_mask", btn_press, got.press);
                check("release_mask", btn_release, got.rel);
                check("repeat_mask", btn_repeat, got.rpt);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int p, dr, d;

        // 1. reset with BTN=0, then the tick runs every TD clocks
        repeat (3) @(negedge clock);
        check("reset_state", btn_state, 0);
        check("reset_press", btn_press, 0);
        check("reset_release", btn_release, 0);
        check("reset_repeat", btn_repeat, 0);
        reset = 1'b0;
        r_cyc = cyc;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            check("tick_phase", dut.tick, (k % TD) == (TD - 1));
        end

        // 2 and 6. BTN[0] pressed and held 60 clocks past its strobe
        d = cyc;
        btn[0] = 1'b1;
        schedule(4'b0001, d, 60, p, dr);
        wait_until(p + 4);
        check("held_state", btn_state, 4'b0001);
        wait_until(dr);
        btn[0] = 1'b0;
        wait_until(last_cyc);
        check("after_release_state", btn_state, 4'b0000);
        wait_until(last_cyc + 3);

        // 3. BTN[1] bounces with 5-clock half periods for 40 clocks
        for (int h = 0; h < 8; h++) begin
            btn[1] = (h % 2 == 0);
            for (int c = 0; c < 5; c++) begin
                @(negedge clock);
                check("bounce_state", btn_state, 4'b0000);
            end
        end
        btn[1] = 1'b0;
        repeat (20) @(negedge clock);
        check("bounce_final_state", btn_state, 4'b0000);

        // 4. BTN[2] and BTN[3] rise and fall together
        d = cyc;
        btn[3:2] = 2'b11;
        schedule(4'b1100, d, 2, p, dr);
        wait_until(p);
        check("joint_state", btn_state, 4'b1100);
        wait_until(dr);
        btn[3:2] = 2'b00;
        wait_until(last_cyc);
        check("joint_release_state", btn_state, 4'b0000);
        wait_until(last_cyc + 3);

        // 5. reset while BTN[0] is still being qualified
        d = cyc;
        btn[0] = 1'b1;
        wait_until(d + 6);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("midpend_reset_state", btn_state, 4'b0000);
            check("midpend_reset_press", btn_press, 4'b0000);
        end
        reset = 1'b0;
        r_cyc = cyc;
        schedule(4'b0001, r_cyc, 2, p, dr);
        wait_until(p);
        check("post_reset_state", btn_state, 4'b0001);
        wait_until(dr);
        btn[0] = 1'b0;
        wait_until(last_cyc + 6);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
